// File: rtl/axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axil_pkg
//  Description : Shared constants, FSM state encodings and helpers for the
//                AXI-Lite line-memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package axil_pkg;

    localparam int AXIL_LINE_W = 128;
    localparam int AXIL_STRB_W = 16;

    localparam logic [31:0] AXIL_RESP_OKAY   = 32'h0000_0000;
    localparam logic [31:0] AXIL_RESP_SLVERR = 32'h0000_0002;
    localparam logic [31:0] AXIL_ERR_RDATA   = 32'hDEAD_BEEF;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_WAIT_DATA = 2'd1,
        W_WAIT_ADDR = 2'd2,
        W_RESP      = 2'd3
    } wr_state_e;

    // Pick one 32-bit word out of a 128-bit line
    function automatic logic [31:0] axil_word_sel(input logic [AXIL_LINE_W-1:0] line,
                                                  input logic [1:0]             sel);
        logic [31:0] word;
        case (sel)
            2'd0:    word = line[31:0];
            2'd1:    word = line[63:32];
            2'd2:    word = line[95:64];
            default: word = line[127:96];
        endcase
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axil_line_ram.sv
`default_nettype none
// ============================================================================
//  Module      : axil_line_ram
//  Description : 2^DEPTH_LOG2 x 128-bit line memory, one synchronous read
//                port and one byte-enabled write port. A read and a write to
//                the same line in one cycle returns the old contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_line_ram
    import axil_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                   clk,
    input  logic                   i_re,
    input  logic [DEPTH_LOG2-1:0]  i_raddr,
    output logic [AXIL_LINE_W-1:0] o_rdata,
    input  logic                   i_we,
    input  logic [DEPTH_LOG2-1:0]  i_waddr,
    input  logic [AXIL_LINE_W-1:0] i_wdata,
    input  logic [AXIL_STRB_W-1:0] i_wstrb
);

    localparam int C_DEPTH = 1 << DEPTH_LOG2;

    logic [AXIL_LINE_W-1:0] mem_q [C_DEPTH];
    logic [AXIL_LINE_W-1:0] rd_line_q;
    logic [AXIL_LINE_W-1:0] rd_line_d;
    logic [AXIL_LINE_W-1:0] w_merged;

    // Read register only updates on a read request so data holds during stalls
    always_comb begin
        rd_line_d = i_re ? mem_q[i_raddr] : rd_line_q;
    end

    // Merge strobed bytes of the new data over the current line contents
    always_comb begin
        w_merged = mem_q[i_waddr];
        for (int i = 0; i < AXIL_STRB_W; i++) begin
            if (i_wstrb[i]) begin
                w_merged[8*i +: 8] = i_wdata[8*i +: 8];
            end
        end
    end

    // Storage and read register; contents are deliberately not reset
    always_ff @(posedge clk) begin
        rd_line_q <= rd_line_d;
        if (i_we) begin
            mem_q[i_waddr] <= w_merged;
        end
    end

    assign o_rdata = rd_line_q;

endmodule
`default_nettype wire

// File: rtl/axil_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : axil_slave_mem
//  Description : AXI-Lite responder with 32-bit reads and 128-bit strobed
//                line writes into an on-chip line memory. Independent read
//                and write FSMs share one axil_line_ram.
//                Optional macro AXIL_SLAVE_RANGE_CHECK_EN: out-of-window
//                writes are dropped with SLVERR, out-of-window reads return
//                AXIL_ERR_RDATA. Without it the line index wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_slave_mem
    import axil_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter int          DEPTH_LOG2 = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [31:0]            readAddr_addr,
    input  logic                   readAddr_valid,
    output logic                   readAddr_ready,
    output logic [31:0]            readData_data,
    output logic                   readData_valid,
    input  logic                   readData_ready,
    input  logic [31:0]            writeAddr_addr,
    input  logic                   writeAddr_valid,
    output logic                   writeAddr_ready,
    input  logic [AXIL_LINE_W-1:0] writeData_data,
    input  logic [AXIL_STRB_W-1:0] writeData_strb,
    input  logic                   writeData_valid,
    output logic                   writeData_ready,
    output logic [31:0]            writeResp_msg,
    output logic                   writeResp_valid,
    input  logic                   writeResp_ready
);

    // ---------------- read channel state ----------------
    rd_state_e   rd_state_q, rd_state_d;
    logic        rd_addr_ready_q, rd_addr_ready_d;
    logic        rd_valid_q, rd_valid_d;
    logic [1:0]  rd_sel_q, rd_sel_d;
    logic        rd_err_q, rd_err_d;

    // ---------------- write channel state ----------------
    wr_state_e              wr_state_q, wr_state_d;
    logic                   wr_addr_ready_q, wr_addr_ready_d;
    logic                   wr_data_ready_q, wr_data_ready_d;
    logic                   wr_resp_valid_q, wr_resp_valid_d;
    logic [31:0]            wr_resp_msg_q, wr_resp_msg_d;
    logic [31:0]            wr_addr_q, wr_addr_d;
    logic [AXIL_LINE_W-1:0] wr_data_q, wr_data_d;
    logic [AXIL_STRB_W-1:0] wr_strb_q, wr_strb_d;

    // ---------------- combinational datapath ----------------
    logic                   w_rd_hs, w_aw_hs, w_w_hs;
    logic [31:0]            w_rd_off, w_wr_off;
    logic                   w_rd_in_range, w_wr_in_range;
    logic                   w_commit;
    logic [31:0]            w_cm_addr;
    logic [AXIL_LINE_W-1:0] w_cm_data;
    logic [AXIL_STRB_W-1:0] w_cm_strb;
    logic [AXIL_LINE_W-1:0] w_rd_line;
    logic                   w_unused;

    assign w_rd_hs  = readAddr_valid  & rd_addr_ready_q;
    assign w_aw_hs  = writeAddr_valid & wr_addr_ready_q;
    assign w_w_hs   = writeData_valid & wr_data_ready_q;
    assign w_rd_off = readAddr_addr - ADDR_BASE;
    assign w_wr_off = w_cm_addr - ADDR_BASE;

`ifdef AXIL_SLAVE_RANGE_CHECK_EN
    // Offset is unsigned, so addresses below the base wrap high and fail too
    assign w_rd_in_range = (w_rd_off[31:DEPTH_LOG2+4] == '0);
    assign w_wr_in_range = (w_wr_off[31:DEPTH_LOG2+4] == '0);
`else
    assign w_rd_in_range = 1'b1;
    assign w_wr_in_range = 1'b1;
`endif

    // Byte offsets within a line and unchecked upper bits are not needed
    assign w_unused = ^{w_rd_off[1:0], w_rd_off[31:DEPTH_LOG2+4],
                        w_wr_off[3:0], w_wr_off[31:DEPTH_LOG2+4]};

    // Commit takes each field either live from the bus or from its latch
    always_comb begin
        w_commit  = 1'b0;
        w_cm_addr = writeAddr_addr;
        w_cm_data = writeData_data;
        w_cm_strb = writeData_strb;
        case (wr_state_q)
            W_IDLE:      w_commit = w_aw_hs & w_w_hs;
            W_WAIT_DATA: begin
                w_commit  = w_w_hs;
                w_cm_addr = wr_addr_q;
            end
            W_WAIT_ADDR: begin
                w_commit  = w_aw_hs;
                w_cm_data = wr_data_q;
                w_cm_strb = wr_strb_q;
            end
            default:     w_commit = 1'b0;
        endcase
    end

    // Reset gates both ports so an abandoned transaction never touches memory
    axil_line_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clock),
        .i_re    (w_rd_hs & ~reset),
        .i_raddr (w_rd_off[DEPTH_LOG2+3:4]),
        .o_rdata (w_rd_line),
        .i_we    (w_commit & w_wr_in_range & ~reset),
        .i_waddr (w_wr_off[DEPTH_LOG2+3:4]),
        .i_wdata (w_cm_data),
        .i_wstrb (w_cm_strb)
    );

    // State and output registers for both channels
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_state_q      <= R_IDLE;
            rd_addr_ready_q <= 1'b0;
            rd_valid_q      <= 1'b0;
            rd_sel_q        <= 2'd0;
            rd_err_q        <= 1'b0;
            wr_state_q      <= W_IDLE;
            wr_addr_ready_q <= 1'b0;
            wr_data_ready_q <= 1'b0;
            wr_resp_valid_q <= 1'b0;
            wr_resp_msg_q   <= AXIL_RESP_OKAY;
            wr_addr_q       <= 32'h0;
            wr_data_q       <= '0;
            wr_strb_q       <= '0;
        end else begin
            rd_state_q      <= rd_state_d;
            rd_addr_ready_q <= rd_addr_ready_d;
            rd_valid_q      <= rd_valid_d;
            rd_sel_q        <= rd_sel_d;
            rd_err_q        <= rd_err_d;
            wr_state_q      <= wr_state_d;
            wr_addr_ready_q <= wr_addr_ready_d;
            wr_data_ready_q <= wr_data_ready_d;
            wr_resp_valid_q <= wr_resp_valid_d;
            wr_resp_msg_q   <= wr_resp_msg_d;
            wr_addr_q       <= wr_addr_d;
            wr_data_q       <= wr_data_d;
            wr_strb_q       <= wr_strb_d;
        end
    end

    // Read FSM next state
    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE:  if (w_rd_hs) rd_state_d = R_DATA;
            R_DATA:  if (rd_valid_q && readData_ready) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Read FSM outputs; readys are registered from the next state
    always_comb begin
        rd_addr_ready_d = (rd_state_d == R_IDLE);
        rd_valid_d      = (rd_state_d == R_DATA);
        rd_sel_d        = w_rd_hs ? w_rd_off[3:2]   : rd_sel_q;
        rd_err_d        = w_rd_hs ? ~w_rd_in_range : rd_err_q;
    end

    // Write FSM next state
    always_comb begin
        wr_state_d = wr_state_q;
        case (wr_state_q)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) wr_state_d = W_RESP;
                else if (w_aw_hs)      wr_state_d = W_WAIT_DATA;
                else if (w_w_hs)       wr_state_d = W_WAIT_ADDR;
            end
            W_WAIT_DATA: if (w_w_hs)  wr_state_d = W_RESP;
            W_WAIT_ADDR: if (w_aw_hs) wr_state_d = W_RESP;
            W_RESP:      if (wr_resp_valid_q && writeResp_ready) wr_state_d = W_IDLE;
            default:     wr_state_d = W_IDLE;
        endcase
    end

    // Write FSM outputs and the latches for whichever half arrived first
    always_comb begin
        wr_addr_ready_d = (wr_state_d == W_IDLE) || (wr_state_d == W_WAIT_ADDR);
        wr_data_ready_d = (wr_state_d == W_IDLE) || (wr_state_d == W_WAIT_DATA);
        wr_resp_valid_d = (wr_state_d == W_RESP);
        wr_resp_msg_d   = wr_resp_msg_q;
        if (w_commit) begin
            wr_resp_msg_d = w_wr_in_range ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
        end
        wr_addr_d = w_aw_hs ? writeAddr_addr : wr_addr_q;
        wr_data_d = w_w_hs  ? writeData_data : wr_data_q;
        wr_strb_d = w_w_hs  ? writeData_strb : wr_strb_q;
    end

    assign readAddr_ready  = rd_addr_ready_q;
    assign readData_valid  = rd_valid_q;
    assign readData_data   = !rd_valid_q ? 32'h0 :
                             rd_err_q    ? AXIL_ERR_RDATA :
                                           axil_word_sel(w_rd_line, rd_sel_q);
    assign writeAddr_ready = wr_addr_ready_q;
    assign writeData_ready = wr_data_ready_q;
    assign writeResp_valid = wr_resp_valid_q;
    assign writeResp_msg   = wr_resp_msg_q;

endmodule
`default_nettype wire

// File: tb/tb_axil_slave_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axil_slave_mem
//  Description : Directed bench for axil_slave_mem. Stimulus tasks push the
//                expected read word / write response into queues; monitors
//                pop and compare whenever a data or response handshake occurs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_slave_mem;

    logic         clock = 1'b0;
    logic         reset;
    logic [31:0]  readAddr_addr;
    logic         readAddr_valid;
    logic         readAddr_ready;
    logic [31:0]  readData_data;
    logic         readData_valid;
    logic         readData_ready;
    logic [31:0]  writeAddr_addr;
    logic         writeAddr_valid;
    logic         writeAddr_ready;
    logic [127:0] writeData_data;
    logic [15:0]  writeData_strb;
    logic         writeData_valid;
    logic         writeData_ready;
    logic [31:0]  writeResp_msg;
    logic         writeResp_valid;
    logic         writeResp_ready;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_r[$];
    logic [31:0] exp_b[$];

    axil_slave_mem dut (
        .clock           (clock),
        .reset           (reset),
        .readAddr_addr   (readAddr_addr),
        .readAddr_valid  (readAddr_valid),
        .readAddr_ready  (readAddr_ready),
        .readData_data   (readData_data),
        .readData_valid  (readData_valid),
        .readData_ready  (readData_ready),
        .writeAddr_addr  (writeAddr_addr),
        .writeAddr_valid (writeAddr_valid),
        .writeAddr_ready (writeAddr_ready),
        .writeData_data  (writeData_data),
        .writeData_strb  (writeData_strb),
        .writeData_valid (writeData_valid),
        .writeData_ready (writeData_ready),
        .writeResp_msg   (writeResp_msg),
        .writeResp_valid (writeResp_valid),
        .writeResp_ready (writeResp_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Read data monitor
    always @(negedge clock) begin
        if (!reset && readData_valid && readData_ready) begin
            if (exp_r.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_unexpected: got %0h, expected no read data", readData_data);
            end else begin
                chk("rd_data", readData_data, exp_r.pop_front());
            end
        end
    end

    // Write response monitor
    always @(negedge clock) begin
        if (!reset && writeResp_valid && writeResp_ready) begin
            if (exp_b.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wr_unexpected: got %0h, expected no response", writeResp_msg);
            end else begin
                chk("wr_resp", writeResp_msg, exp_b.pop_front());
            end
        end
    end

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input int stall);
        int cyc = 0;
        bit hs  = 1'b0;
        exp_r.push_back(e);
        readData_ready = (stall == 0);
        readAddr_addr  = a;
        readAddr_valid = 1'b1;
        while (!hs) begin
            @(negedge clock);
            hs = readAddr_ready;
            @(posedge clock); #1;
            cyc++;
            if (!hs && cyc > 20) begin
                n_vec++;
                n_err++;
                $display("FAIL rd_addr_timeout: got no readAddr_ready, expected one within 20 cycles");
                break;
            end
        end
        readAddr_valid = 1'b0;
        @(negedge clock);
        chk("rd_latency_valid", readData_valid, 1);
        for (int i = 0; i < stall; i++) begin
            chk("rd_hold_data", readData_data, e);
            chk("rd_hold_arready", readAddr_ready, 0);
            @(posedge clock); #1;
            @(negedge clock);
            chk("rd_hold_valid", readData_valid, 1);
        end
        @(posedge clock); #1;
        if (stall > 0) begin
            readData_ready = 1'b1;
            @(negedge clock);
            @(posedge clock); #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s,
                      input logic [31:0] e, input int aw_dly, input int w_dly, input int bstall);
        int cyc      = 0;
        bit aw_done  = 1'b0;
        bit w_done   = 1'b0;
        bit aw_hs, w_hs;
        exp_b.push_back(e);
        writeResp_ready = (bstall == 0);
        writeAddr_addr  = a;
        writeData_data  = d;
        writeData_strb  = s;
        while (!(aw_done && w_done)) begin
            if (!aw_done && cyc >= aw_dly) writeAddr_valid = 1'b1;
            if (!w_done  && cyc >= w_dly)  writeData_valid = 1'b1;
            @(negedge clock);
            if (w_done)  chk("wr_wait_addr_wready", writeData_ready, 0);
            if (aw_done) chk("wr_wait_data_awready", writeAddr_ready, 0);
            aw_hs = writeAddr_valid && writeAddr_ready;
            w_hs  = writeData_valid && writeData_ready;
            @(posedge clock); #1;
            if (aw_hs) begin writeAddr_valid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin writeData_valid = 1'b0; w_done  = 1'b1; end
            cyc++;
            if (!(aw_done && w_done) && cyc > 40) begin
                n_vec++;
                n_err++;
                $display("FAIL wr_hs_timeout: got aw=%0d w=%0d, expected both within 40 cycles", aw_done, w_done);
                writeAddr_valid = 1'b0;
                writeData_valid = 1'b0;
                break;
            end
        end
        @(negedge clock);
        chk("wr_resp_latency", writeResp_valid, 1);
        for (int i = 0; i < bstall; i++) begin
            chk("wr_hold_msg", writeResp_msg, e);
            chk("wr_hold_awready", writeAddr_ready, 0);
            chk("wr_hold_wready", writeData_ready, 0);
            @(posedge clock); #1;
            @(negedge clock);
            chk("wr_hold_valid", writeResp_valid, 1);
        end
        @(posedge clock); #1;
        if (bstall > 0) begin
            writeResp_ready = 1'b1;
            @(negedge clock);
            @(posedge clock); #1;
        end
    endtask

    // Outputs while reset is held, then readys rising one cycle after release
    task automatic reset_seq(input string tag);
        reset = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(negedge clock);
        chk({tag, "_rvalid"}, readData_valid, 0);
        chk({tag, "_rdata"}, readData_data, 0);
        chk({tag, "_bvalid"}, writeResp_valid, 0);
        chk({tag, "_bmsg"}, writeResp_msg, 0);
        chk({tag, "_arready"}, readAddr_ready, 0);
        chk({tag, "_awready"}, writeAddr_ready, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk({tag, "_wready_low"}, writeData_ready, 0);
        @(negedge clock);
        chk({tag, "_arready_up"}, readAddr_ready, 1);
        chk({tag, "_awready_up"}, writeAddr_ready, 1);
        chk({tag, "_wready_up"}, writeData_ready, 1);
        @(posedge clock); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, expected finish before 300us");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        readAddr_addr   = 32'h0;
        readAddr_valid  = 1'b0;
        readData_ready  = 1'b1;
        writeAddr_addr  = 32'h0;
        writeAddr_valid = 1'b0;
        writeData_data  = '0;
        writeData_strb  = '0;
        writeData_valid = 1'b0;
        writeResp_ready = 1'b1;
        @(posedge clock); #1;
        reset_seq("rst");

        // Write a line then read back its four words
        wr(32'h10, 128'h0000_0004_0000_0003_0000_0002_0000_0001, 16'hFFFF, 32'h0, 0, 0, 0);
        rd(32'h10, 32'h1, 0);
        rd(32'h14, 32'h2, 0);
        rd(32'h18, 32'h3, 0);
        rd(32'h1C, 32'h4, 0);

        // Partial strobe and zero-strobe no-op
        wr(32'h20, {128{1'b1}}, 16'hFFFF, 32'h0, 0, 0, 0);
        wr(32'h20, 128'h0, 16'h000F, 32'h0, 0, 0, 0);
        rd(32'h20, 32'h0, 0);
        rd(32'h24, 32'hFFFF_FFFF, 0);
        wr(32'h28, 128'h0, 16'h0000, 32'h0, 0, 0, 0);
        rd(32'h28, 32'hFFFF_FFFF, 0);

        // Split writes: data first then address, and address first then data
        wr(32'h40, 128'h4000_0003_4000_0002_4000_0001_4000_0000, 16'hFFFF, 32'h0, 3, 0, 0);
        rd(32'h48, 32'h4000_0002, 0);
        wr(32'h50, 128'h5000_0003_5000_0002_5000_0001_5000_0000, 16'hFFFF, 32'h0, 0, 2, 0);
        rd(32'h5C, 32'h5000_0003, 0);

        // Backpressure on read data and on write response
        rd(32'h14, 32'h2, 5);
        wr(32'h70, 128'h7000_0003_7000_0002_7000_0001_7000_0000, 16'hFFFF, 32'h0, 0, 0, 4);
        rd(32'h70, 32'h7000_0000, 0);

        // Read latched in the same cycle as a commit to that line sees old data
        wr(32'h60, 128'hA3A3_A3A3_A2A2_A2A2_A1A1_A1A1_A0A0_A0A0, 16'hFFFF, 32'h0, 0, 0, 0);
        fork
            rd(32'h64, 32'hA1A1_A1A1, 0);
            wr(32'h60, 128'hB3B3_B3B3_B2B2_B2B2_B1B1_B1B1_B0B0_B0B0, 16'hFFFF, 32'h0, 0, 0, 0);
        join
        rd(32'h64, 32'hB1B1_B1B1, 0);

        // Reset while waiting for write data abandons the write
        wr(32'h30, 128'hC0DE_0003_C0DE_0002_C0DE_0001_C0DE_0000, 16'hFFFF, 32'h0, 0, 0, 0);
        writeAddr_addr  = 32'h30;
        writeAddr_valid = 1'b1;
        @(negedge clock);
        chk("rst_mid_awready", writeAddr_ready, 1);
        @(posedge clock); #1;
        writeAddr_valid = 1'b0;
        @(negedge clock);
        chk("rst_mid_wait_awready", writeAddr_ready, 0);
        chk("rst_mid_wait_wready", writeData_ready, 1);
        @(posedge clock); #1;
        writeData_data  = 128'h0;
        writeData_strb  = 16'hFFFF;
        writeData_valid = 1'b1;
        reset           = 1'b1;
        @(posedge clock); #1;
        writeData_valid = 1'b0;
        reset_seq("rst_mid");
        rd(32'h30, 32'hC0DE_0000, 0);
        rd(32'h3C, 32'hC0DE_0003, 0);

        // Out-of-window address handling
        wr(32'h0, 128'h0D00_0003_0D00_0002_0D00_0001_0D00_0000, 16'hFFFF, 32'h0, 0, 0, 0);
`ifdef AXIL_SLAVE_RANGE_CHECK_EN
        wr(32'h1000, 128'hE000_0003_E000_0002_E000_0001_E000_0000, 16'hFFFF, 32'h2, 0, 0, 0);
        rd(32'h0, 32'h0D00_0000, 0);
        rd(32'h1000, 32'hDEAD_BEEF, 0);
`else
        wr(32'h1000, 128'hE000_0003_E000_0002_E000_0001_E000_0000, 16'hFFFF, 32'h0, 0, 0, 0);
        rd(32'h0, 32'hE000_0000, 0);
        rd(32'h1004, 32'hE000_0001, 0);
`endif

        repeat (3) @(posedge clock);
        chk("rd_queue_drained", exp_r.size(), 0);
        chk("wr_queue_drained", exp_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
